// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// cmp_pkg : shared types and constants for frame_minmax_tracker
// Rev 1.0 : initial release
// ============================================================================
package cmp_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = {CNT_W_DEFAULT{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

endpackage
`default_nettype wire

// File: rtl/minmax_cmp_unit.sv
`default_nettype none
// ============================================================================
// minmax_cmp_unit : combinational magnitude compare of a sample against min/max
// Rev 1.0 : initial release
// ============================================================================
module minmax_cmp_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_max,
    output logic             lt_min,
    output logic             eq_min,
    output logic             gt_max,
    output logic             eq_max
);

    assign lt_min = (sample <  cur_min);
    assign eq_min = (sample == cur_min);
    assign gt_max = (sample >  cur_max);
    assign eq_max = (sample == cur_max);

endmodule
`default_nettype wire

// File: rtl/frame_minmax_tracker.sv
`default_nettype none
// ============================================================================
// frame_minmax_tracker : per-frame min/max/first-index/count of a sample stream
// Rev 1.0 : initial release
// ============================================================================
module frame_minmax_tracker
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_flat,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_min_idx;
    logic [CNT_W-1:0] r_max_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_flat;
    logic             r_sat;
    logic             w_accept;
    logic             w_lt_min;
    logic             w_eq_min;
    logic             w_gt_max;
    logic             w_eq_max;

    minmax_cmp_unit #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .sample  (in_data),
        .cur_min (r_min),
        .cur_max (r_max),
        .lt_min  (w_lt_min),
        .eq_min  (w_eq_min),
        .gt_max  (w_gt_max),
        .eq_max  (w_eq_max)
    );

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Result registers only move on accepted samples, so they are frozen in HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min     <= '0;
            r_max     <= '0;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_count   <= '0;
            r_flat    <= 1'b0;
            r_sat     <= 1'b0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_min     <= in_data;
                r_max     <= in_data;
                r_min_idx <= '0;
                r_max_idx <= '0;
                r_count   <= c_cnt_one;
                r_flat    <= 1'b1;
                r_sat     <= 1'b0;
            end else begin
                if (w_lt_min) begin
                    r_min     <= in_data;
                    r_min_idx <= r_count;
                end
                if (w_gt_max) begin
                    r_max     <= in_data;
                    r_max_idx <= r_count;
                end
                if (r_count == c_cnt_max) begin
                    r_sat <= 1'b1;
                end else begin
                    r_count <= r_count + c_cnt_one;
                end
                // While min==max, any sample off that value breaks flatness for good.
                r_flat <= r_flat && w_eq_min && w_eq_max;
            end
        end
    end

    assign out_min     = r_min;
    assign out_max     = r_max;
    assign out_min_idx = r_min_idx;
    assign out_max_idx = r_max_idx;
    assign out_count   = r_count;
    assign out_flat    = r_flat;
    assign out_sat     = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_frame_minmax_tracker.sv
`default_nettype none
// ============================================================================
// tb_frame_minmax_tracker : directed + random frames against a reference model
// Rev 1.0 : initial release
// ============================================================================
module tb_frame_minmax_tracker;

    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [31:0] mn_idx;
        logic [31:0] mx_idx;
        logic [31:0] cnt;
        logic [31:0] flat;
        logic [31:0] sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_flat, a_sat;
    logic [7:0]  a_min, a_max;
    logic [15:0] a_min_idx, a_max_idx, a_count;
    logic        b_in_ready, b_out_valid, b_flat, b_sat;
    logic [7:0]  b_min, b_max;
    logic [2:0]  b_min_idx, b_max_idx, b_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frame_minmax_tracker #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_min(a_min), .out_max(a_max),
        .out_min_idx(a_min_idx), .out_max_idx(a_max_idx), .out_count(a_count),
        .out_flat(a_flat), .out_sat(a_sat)
    );

    frame_minmax_tracker #(.WIDTH(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_min(b_min), .out_max(b_max),
        .out_min_idx(b_min_idx), .out_max_idx(b_max_idx), .out_count(b_count),
        .out_flat(b_flat), .out_sat(b_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: statistics of the whole frame, then clamp to what a cmax counter can show.
    function automatic exp_t model(input logic [7:0] q[$], input int cmax);
        exp_t e;
        int mn, mx, mni, mxi, n;
        mn = 256; mx = -1; mni = 0; mxi = 0;
        n = q.size();
        foreach (q[i]) begin
            if (int'(q[i]) < mn) begin mn = int'(q[i]); mni = i; end
            if (int'(q[i]) > mx) begin mx = int'(q[i]); mxi = i; end
        end
        e.mn     = 32'(mn);
        e.mx     = 32'(mx);
        e.mn_idx = 32'((mni > cmax) ? cmax : mni);
        e.mx_idx = 32'((mxi > cmax) ? cmax : mxi);
        e.cnt    = 32'((n > cmax) ? cmax : n);
        e.flat   = 32'(mn == mx);
        e.sat    = 32'(n > cmax);
        return e;
    endfunction

    task automatic check_result(input string ph, input exp_t ea, input exp_t eb);
        check({ph, ".valid"},   32'(a_out_valid), 32'd1);
        check({ph, ".ready"},   32'(a_in_ready),  32'd0);
        check({ph, ".min"},     32'(a_min),       ea.mn);
        check({ph, ".max"},     32'(a_max),       ea.mx);
        check({ph, ".min_idx"}, 32'(a_min_idx),   ea.mn_idx);
        check({ph, ".max_idx"}, 32'(a_max_idx),   ea.mx_idx);
        check({ph, ".count"},   32'(a_count),     ea.cnt);
        check({ph, ".flat"},    32'(a_flat),      ea.flat);
        check({ph, ".sat"},     32'(a_sat),       ea.sat);
        check({ph, ".s_valid"},   32'(b_out_valid), 32'd1);
        check({ph, ".s_min"},     32'(b_min),       eb.mn);
        check({ph, ".s_max"},     32'(b_max),       eb.mx);
        check({ph, ".s_min_idx"}, 32'(b_min_idx),   eb.mn_idx);
        check({ph, ".s_max_idx"}, 32'(b_max_idx),   eb.mx_idx);
        check({ph, ".s_count"},   32'(b_count),     eb.cnt);
        check({ph, ".s_flat"},    32'(b_flat),      eb.flat);
        check({ph, ".s_sat"},     32'(b_sat),       eb.sat);
    endtask

    // Called at a negedge with the sample already presented; returns at the negedge after acceptance.
    task automatic wait_accept(input string ph);
        int t;
        t = 0;
        while (!a_in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check({ph, ".accept_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic push_sample(input string ph, input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        wait_accept(ph);
    endtask

    task automatic send_frame(input string ph, input logic [7:0] q[$], input int gap_pct, input int bp);
        exp_t ea, eb;
        ea = model(q, 65535);
        eb = model(q, 7);
        out_ready = (bp == 0);
        foreach (q[i]) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            push_sample(ph, q[i], (i == q.size() - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result(ph, ea, eb);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check_result({ph, ".hold"}, ea, eb);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({ph, ".released"}, 32'(a_out_valid), 32'd0);
        check({ph, ".ready_back"}, 32'(a_in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int len;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.out_valid", 32'(a_out_valid), 32'd0);
        check("rst.in_ready",  32'(a_in_ready),  32'd1);
        check("rst.min",       32'(a_min),       32'd0);
        check("rst.max",       32'(a_max),       32'd0);
        check("rst.count",     32'(a_count),     32'd0);
        check("rst.flat",      32'(a_flat),      32'd0);
        check("rst.sat",       32'(a_sat),       32'd0);

        q = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd9};
        send_frame("basic", q, 0, 0);

        q = '{8'hA5};
        send_frame("single", q, 0, 0);

        q = '{8'h3C, 8'h11};
        send_frame("backpressure", q, 0, 4);
        q = '{8'd7, 8'd7};
        send_frame("flat", q, 0, 0);

        q = '{8'hFF, 8'h00, 8'h80};
        send_frame("bubbles", q, 100, 0);

        q = '{8'd50, 8'd40, 8'd60, 8'd30, 8'd70, 8'd20, 8'd80, 8'd10, 8'd90};
        send_frame("saturate", q, 0, 0);

        push_sample("midreset", 8'd12, 1'b0);
        push_sample("midreset", 8'd34, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midreset.no_valid",   32'(a_out_valid), 32'd0);
            check("midreset.s_no_valid", 32'(b_out_valid), 32'd0);
        end
        q = '{8'd4};
        send_frame("after_reset", q, 0, 0);

        for (int f = 0; f < 30; f++) begin
            q.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if (f % 3 == 0) q.push_back(8'($urandom_range(0, 3)));
                else            q.push_back(8'($urandom));
            end
            send_frame("random", q, 30, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
